vga_fb_scheduler: RTL and testbench

- Owns a single-port 80x60 tile framebuffer (8x8-pixel tiles, 3-bit RGB per tile) for the 640x480 VGA path.
- Schedules the RAM between three users: scan-out reads driven by the row/col counters of sync_pulse_gen, host tile writes over a valid/ready handshake, and a full-screen clear engine.
- Scan-out always wins. The block emits pixel colour with HSync/VSync delayed to match.
- Sits between sync_pulse_gen and the VGA pins in the top level.

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_tile_ram.sv | 30 +++
 rtl/vga_fb_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_vga_fb_scheduler.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the tile framebuffer path.
//   H_ACTIVE/V_ACTIVE : visible area in pixels
//   H_TOTAL/V_TOTAL   : full raster including blanking
//   TILE_LOG2         : tile edge is 2^TILE_LOG2 pixels
//   TILES_X/TILES_Y   : tile grid of the visible area
//   ADDR_W            : tile RAM address width
//   tile_addr()       : row-major tile address, y*80 + x without a multiplier
package vga_pkg;

  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int H_TOTAL    = 800;
  localparam int V_TOTAL    = 525;
  localparam int TILE_LOG2  = 3;
  localparam int TILES_X    = H_ACTIVE >> TILE_LOG2;
  localparam int TILES_Y    = V_ACTIVE >> TILE_LOG2;
  localparam int TILE_COUNT = TILES_X * TILES_Y;
  localparam int ADDR_W     = 13;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;

  typedef logic [2:0] rgb_t;

  // y*80 built as y*64 + y*16 so it maps onto adders only.
  function automatic logic [ADDR_W-1:0] tile_addr(input logic [6:0] ty,
                                                  input logic [6:0] tx);
    logic [ADDR_W-1:0] y_w;
    y_w = ADDR_W'(ty);
    return (y_w << 6) + (y_w << 4) + ADDR_W'(tx);
  endfunction

endpackage

// File: rtl/vga_tile_ram.sv
// Single-port tile store, one RGB triple per 8x8 tile.
//   clk   : pixel clock
//   we    : write enable for this cycle's address
//   addr  : tile address (row-major, 0..TILE_COUNT-1)
//   wdata : colour to store
//   rdata : colour at the previous cycle's address (1-cycle registered read)
// Contents are never reset so the array maps onto block RAM.
module vga_tile_ram
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  rgb_t              wdata,
  output rgb_t              rdata
);

  rgb_t mem [TILE_COUNT];
  rgb_t rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_reg <= mem[addr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/vga_fb_scheduler.sv
// Tile framebuffer owner for the 640x480 VGA path. Arbitrates the single RAM
// port between scan-out reads, host tile writes and a full-screen clear, and
// produces pixel colour with the sync signals delayed to line up.
//   clk, rst             : pixel clock, synchronous active-high reset
//   row, col             : raster position from the sync generator
//   HSync_in, VSync_in   : syncs from the sync generator
//   wr_valid/wr_ready    : host tile write handshake (wr_x, wr_y, wr_color)
//   clr_start, clr_color : start a clear of every tile with clr_color
//   clr_busy, clr_done   : clear in progress / one-cycle completion pulse
//   HSync_out, VSync_out : syncs delayed by 2 cycles
//   VGA_R/G/B            : pixel colour, 2 cycles after row/col, 0 in blanking
module vga_fb_scheduler
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] row,
  input  logic [9:0] col,
  input  logic       HSync_in,
  input  logic       VSync_in,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [6:0] wr_x,
  input  logic [5:0] wr_y,
  input  logic [2:0] wr_color,
  input  logic       clr_start,
  input  logic [2:0] clr_color,
  output logic       clr_busy,
  output logic       clr_done,
  output logic       HSync_out,
  output logic       VSync_out,
  output logic       VGA_R,
  output logic       VGA_G,
  output logic       VGA_B
);

  logic              active;
  logic              scan_slot;
  logic [ADDR_W-1:0] scan_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_in_range;
  logic              wr_fire;
  logic              clr_we;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  rgb_t              ram_wdata;
  rgb_t              ram_rdata;

  clr_state_t        state_reg;
  logic [ADDR_W-1:0] clr_addr_reg;
  rgb_t              clr_color_reg;
  logic              clr_busy_reg;
  logic              clr_done_reg;

  logic [1:0]        hs_pipe_reg;
  logic [1:0]        vs_pipe_reg;
  logic              active_d1_reg;
  logic              slot_d1_reg;
  rgb_t              tile_color_reg;
  rgb_t              pix_reg;

  // One RAM read per tile per scanline: only on the first pixel of a tile.
  assign active    = (col < 10'(H_ACTIVE)) && (row < 10'(V_ACTIVE));
  assign scan_slot = active && (col[TILE_LOG2-1:0] == '0);
  assign scan_addr = tile_addr(row[9:TILE_LOG2], col[9:TILE_LOG2]);

  assign wr_addr     = tile_addr({1'b0, wr_y}, wr_x);
  assign wr_in_range = (wr_x < 7'(TILES_X)) && (wr_y < 6'(TILES_Y));

  // The host is only refused when scan-out owns the port or a clear runs.
  assign wr_ready = !scan_slot && (state_reg == IDLE) && !rst;
  // Out-of-range writes still complete the handshake but never reach RAM.
  assign wr_fire  = wr_valid && wr_ready && wr_in_range;
  // Gating on rst keeps an aborted clear from writing one extra tile.
  assign clr_we   = (state_reg == CLEAR) && !scan_slot && !rst;

  // Port mux: scan read > clear write > host write.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = scan_addr;
    ram_wdata = clr_color_reg;
    if (scan_slot) begin
      ram_addr = scan_addr;
    end else if (clr_we) begin
      ram_we    = 1'b1;
      ram_addr  = clr_addr_reg;
      ram_wdata = clr_color_reg;
    end else if (wr_fire) begin
      ram_we    = 1'b1;
      ram_addr  = wr_addr;
      ram_wdata = wr_color;
    end
  end

  vga_tile_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Clear engine: walks every tile address once, yielding to scan slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      clr_addr_reg  <= '0;
      clr_color_reg <= '0;
      clr_busy_reg  <= 1'b0;
      clr_done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (clr_start) begin
            clr_color_reg <= clr_color;
            clr_addr_reg  <= '0;
            clr_busy_reg  <= 1'b1;
            state_reg     <= CLEAR;
          end
        end
        CLEAR: begin
          if (!scan_slot) begin
            if (clr_addr_reg == ADDR_W'(TILE_COUNT - 1)) begin
              clr_done_reg <= 1'b1;
              state_reg    <= DONE;
            end else begin
              clr_addr_reg <= clr_addr_reg + 1'b1;
            end
          end
        end
        DONE: begin
          clr_busy_reg <= 1'b0;
          clr_done_reg <= 1'b0;
          state_reg    <= IDLE;
        end
        default: begin
          clr_busy_reg <= 1'b0;
          clr_done_reg <= 1'b0;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

  assign clr_busy = clr_busy_reg;
  assign clr_done = clr_done_reg;

  // Output pipeline. Stage 1 is the RAM read and the delayed flags; stage 2
  // is the colour register. The tile that was just read is forwarded
  // straight from the RAM so the first pixel of a tile is not a cycle late.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_pipe_reg    <= 2'b11;
      vs_pipe_reg    <= 2'b11;
      active_d1_reg  <= 1'b0;
      slot_d1_reg    <= 1'b0;
      tile_color_reg <= '0;
      pix_reg        <= '0;
    end else begin
      hs_pipe_reg   <= {hs_pipe_reg[0], HSync_in};
      vs_pipe_reg   <= {vs_pipe_reg[0], VSync_in};
      active_d1_reg <= active;
      slot_d1_reg   <= scan_slot;
      if (slot_d1_reg) begin
        tile_color_reg <= ram_rdata;
      end
      if (!active_d1_reg) begin
        pix_reg <= '0;
      end else if (slot_d1_reg) begin
        pix_reg <= ram_rdata;
      end else begin
        pix_reg <= tile_color_reg;
      end
    end
  end

  assign HSync_out = hs_pipe_reg[1];
  assign VSync_out = vs_pipe_reg[1];
  assign VGA_R     = pix_reg[2];
  assign VGA_G     = pix_reg[1];
  assign VGA_B     = pix_reg[0];

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Testbench for vga_fb_scheduler: a tile-level framebuffer model checks all
// outputs every cycle, and directed scenarios add literal expectations.
module tb_vga_fb_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] row = '0;
  logic [9:0] col = '0;
  logic       HSync_in = 1'b1;
  logic       VSync_in = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [6:0] wr_x = '0;
  logic [5:0] wr_y = '0;
  logic [2:0] wr_color = '0;
  logic       clr_start = 1'b0;
  logic [2:0] clr_color = '0;
  logic       clr_busy;
  logic       clr_done;
  logic       HSync_out;
  logic       VSync_out;
  logic       VGA_R;
  logic       VGA_G;
  logic       VGA_B;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  vga_fb_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .HSync_in  (HSync_in),
    .VSync_in  (VSync_in),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_color  (wr_color),
    .clr_start (clr_start),
    .clr_color (clr_color),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .HSync_out (HSync_out),
    .VSync_out (VSync_out),
    .VGA_R     (VGA_R),
    .VGA_G     (VGA_G),
    .VGA_B     (VGA_B)
  );

  task automatic chk(input string name, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- framebuffer model ----------------
  logic [2:0] fb       [4800];
  bit         fb_known [4800];
  int         q_pix [2];          // [0] newest; -1 = colour not known
  bit         q_hs  [2];
  bit         q_vs  [2];
  int         tile_seen = 0;
  bit         m_busy = 0;
  bit         m_done = 0;
  int         m_ptr = 0;
  logic [2:0] m_col = '0;
  bit         model_on = 0;

  function automatic bit is_active(input int r, input int c);
    return (c < 640) && (r < 480);
  endfunction

  function automatic bit is_slot(input int r, input int c);
    return is_active(r, c) && (c % 8 == 0);
  endfunction

  always @(posedge clk) begin : model
    int pix;
    int t;
    bit s;
    s = is_slot(int'(row), int'(col));
    if (rst) begin
      model_on  = 1;
      q_pix[0]  = 0; q_pix[1] = 0;
      q_hs[0]   = 1; q_hs[1]  = 1;
      q_vs[0]   = 1; q_vs[1]  = 1;
      tile_seen = 0;
      m_busy    = 0;
      m_done    = 0;
    end else begin
      if (!is_active(int'(row), int'(col))) begin
        pix = 0;
      end else if (s) begin
        t = (int'(row) / 8) * 80 + int'(col) / 8;
        pix = fb_known[t] ? int'(fb[t]) : -1;
        tile_seen = pix;
      end else begin
        pix = tile_seen;
      end
      q_pix[1] = q_pix[0]; q_pix[0] = pix;
      q_hs[1]  = q_hs[0];  q_hs[0]  = HSync_in;
      q_vs[1]  = q_vs[0];  q_vs[0]  = VSync_in;

      if (m_done) begin
        m_done = 0;
        m_busy = 0;
      end else if (m_busy) begin
        if (!s) begin
          fb[m_ptr] = m_col;
          fb_known[m_ptr] = 1;
          m_ptr++;
          if (m_ptr == 4800) m_done = 1;
        end
      end else begin
        if (wr_valid && !s && int'(wr_x) < 80 && int'(wr_y) < 60) begin
          t = int'(wr_y) * 80 + int'(wr_x);
          fb[t] = wr_color;
          fb_known[t] = 1;
        end
        if (clr_start) begin
          m_busy = 1;
          m_ptr  = 0;
          m_col  = clr_color;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    if (model_on) begin
      chk("wr_ready", int'(wr_ready),
          int'(!rst && !is_slot(int'(row), int'(col)) && !m_busy));
      chk("clr_busy", int'(clr_busy), int'(m_busy));
      chk("clr_done", int'(clr_done), int'(m_done));
      chk("hsync_out", int'(HSync_out), int'(q_hs[1]));
      chk("vsync_out", int'(VSync_out), int'(q_vs[1]));
      if (q_pix[1] >= 0) chk("rgb", int'({VGA_R, VGA_G, VGA_B}), q_pix[1]);
    end
  end

  // ---------------- stimulus helpers ----------------
  int fr_row = 0;
  int fr_col = 0;

  task automatic present(input int r, input int c);
    row      = 10'(r);
    col      = 10'(c);
    HSync_in = !(c >= 656 && c < 752);
    VSync_in = !(r >= 490 && r < 492);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic free_tick();
    present(fr_row, fr_col);
    step();
    fr_col++;
    if (fr_col == 800) begin
      fr_col = 0;
      fr_row = (fr_row == 524) ? 0 : fr_row + 1;
    end
  endtask

  function automatic int rgb_now();
    return int'({VGA_R, VGA_G, VGA_B});
  endfunction

  // Full clear under free-running counters, with a second clr_start mid-way.
  task automatic run_clear(input logic [2:0] color);
    int  done_cnt;
    bit  seen;
    done_cnt  = 0;
    seen      = 0;
    clr_color = color;
    clr_start = 1'b1;
    free_tick();
    clr_start = 1'b0;
    chk("clr_busy_rise", int'(clr_busy), 1);
    for (int n = 0; n < 20000 && !seen; n++) begin
      if (n == 100) begin
        clr_start = 1'b1;
        clr_color = 3'b110;
      end
      free_tick();
      clr_start = 1'b0;
      if (clr_done) begin
        done_cnt++;
        seen = 1;
      end
    end
    chk("clr_finished", int'(seen), 1);
    for (int k = 0; k < 16; k++) begin
      free_tick();
      if (clr_done) done_cnt++;
    end
    chk("clr_done_pulses", done_cnt, 1);
    chk("clr_busy_after", int'(clr_busy), 0);
  endtask

  // Scan one full line; obs[c] is the colour shown for column c.
  int obs [800];
  int pre_out;

  task automatic scan_row(input int r);
    present(r, 700);
    step();
    for (int c = 0; c < 800; c++) begin
      present(r, c);
      step();
      if (c == 0) pre_out = rgb_now();
      else obs[c-1] = rgb_now();
    end
    present(r, 700);
    step();
    obs[799] = rgb_now();
  endtask

  // Visit every tile twice (first and last pixel) and count shown colours.
  task automatic readback(input int ca, output int cnt_a, input int cb, output int cnt_b);
    cnt_a = 0;
    cnt_b = 0;
    present(500, 0);
    step();
    step();
    for (int y = 0; y < 60; y++) begin
      for (int x = 0; x < 80; x++) begin
        for (int k = 0; k < 2; k++) begin
          present(y * 8 + 3, x * 8 + k * 7);
          step();
          if (rgb_now() == ca) cnt_a++;
          if (rgb_now() == cb) cnt_b++;
        end
      end
    end
    present(500, 0);
    for (int k = 0; k < 2; k++) begin
      step();
      if (rgb_now() == ca) cnt_a++;
      if (rgb_now() == cb) cnt_b++;
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : stim
    int acc;
    int stall;
    int na;
    int nb;
    int nz;

    // Reset held 3 cycles.
    present(0, 0);
    for (int i = 0; i < 3; i++) step();
    chk("rst_rgb", rgb_now(), 0);
    chk("rst_hsync", int'(HSync_out), 1);
    chk("rst_vsync", int'(VSync_out), 1);
    chk("rst_wr_ready", int'(wr_ready), 0);
    chk("rst_clr_busy", int'(clr_busy), 0);
    chk("rst_clr_done", int'(clr_done), 0);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) free_tick();

    // Clear to blue; the mid-clear clr_start (colour 110) must be ignored.
    run_clear(3'b001);

    // Host write of a red tile at (1,0) in blanking.
    present(500, 0);
    wr_valid = 1'b1; wr_x = 7'd1; wr_y = 6'd0; wr_color = 3'b100;
    #1;
    chk("wr_ready_blank", int'(wr_ready), 1);
    step();
    wr_valid = 1'b0;

    scan_row(0);
    chk("row0_pre", pre_out, 0);
    chk("row0_col0", obs[0], 3'b001);
    chk("row0_col7", obs[7], 3'b001);
    chk("row0_col8", obs[8], 3'b100);
    chk("row0_col15", obs[15], 3'b100);
    chk("row0_col16", obs[16], 3'b001);
    chk("row0_col639", obs[639], 3'b001);
    chk("row0_col640", obs[640], 0);
    nz = 0;
    for (int c = 0; c < 800; c++) if (obs[c] == 3'b100) nz++;
    chk("row0_red_pixels", nz, 8);

    // wr_valid held over a whole active line.
    acc = 0;
    stall = 0;
    wr_valid = 1'b1; wr_x = 7'd5; wr_y = 6'd5; wr_color = 3'b011;
    for (int c = 0; c < 800; c++) begin
      present(100, c);
      #1;
      if (wr_ready) acc++;
      else stall++;
      step();
    end
    wr_valid = 1'b0;
    chk("hold_accepted", acc, 720);
    chk("hold_stalled", stall, 80);

    // Out-of-range write: (80,5) would alias tile (0,6) if not dropped.
    present(500, 0);
    wr_valid = 1'b1; wr_x = 7'd80; wr_y = 6'd5; wr_color = 3'b111;
    #1;
    chk("wr_ready_oob", int'(wr_ready), 1);
    step();
    wr_valid = 1'b0;
    scan_row(48);
    chk("oob_tile0_6", obs[0], 3'b001);
    nz = 0;
    for (int c = 0; c < 800; c++) if (obs[c] == 3'b111) nz++;
    chk("oob_white_pixels", nz, 0);
    scan_row(40);
    chk("tile5_5_col39", obs[39], 3'b001);
    chk("tile5_5_col40", obs[40], 3'b011);
    chk("tile5_5_col48", obs[48], 3'b001);

    // Clear to white, then read every tile back and sweep some blanking.
    run_clear(3'b111);
    readback(3'b111, na, 3'b001, nb);
    chk("white_tiles", na, 9600);
    chk("blue_left", nb, 0);
    nz = 0;
    for (int c = 640; c < 800; c++) begin
      present(479, c);
      step();
      if (rgb_now() != 0) nz++;
    end
    for (int r = 480; r < 525; r += 11) begin
      present(r, 8);
      step();
      if (rgb_now() != 0) nz++;
    end
    step();
    if (rgb_now() != 0) nz++;
    chk("blank_nonzero", nz, 0);

    // Clear to green with no scan slots, aborted by rst at address 2000.
    present(500, 0);
    clr_color = 3'b010;
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    chk("abort_busy_rise", int'(clr_busy), 1);
    for (int i = 0; i < 2000; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", int'(clr_busy), 0);
    chk("abort_done", int'(clr_done), 0);
    nz = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (clr_done || clr_busy) nz++;
    end
    chk("abort_quiet", nz, 0);
    readback(3'b010, na, 3'b111, nb);
    chk("abort_green_tiles", na, 4000);
    chk("abort_white_tiles", nb, 5600);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
